// File: rtl/noise_inject_ctrl.sv
// Noise-generator sequencer: holds the generator in reset while idle, runs a warm-up,
// then streams scaled/saturated 16-bit samples on a valid/ready port with drop accounting.
module noise_inject_ctrl #(
    parameter int WARMUP_CYC = 8,
    parameter int CNT_W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          cfg_mode,
    input  logic [4:0]          cfg_shift,
    input  logic [CNT_W-1:0]    cfg_burst,
    input  logic signed [31:0]  gauss_in,
    input  logic signed [31:0]  white_in,
    input  logic signed [31:0]  pink_in,
    output logic                gen_rst,
    output logic signed [15:0]  out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         drop_cnt
);

    localparam int WC_W = (WARMUP_CYC < 2) ? 1 : $clog2(WARMUP_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WARM  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef struct packed {
        logic [1:0]       mode;
        logic [4:0]       shift;
        logic [CNT_W-1:0] burst;
    } cfg_t;

    logic [2:0]         state, nxt;
    cfg_t               cfg_q;
    logic [WC_W-1:0]    wcnt;
    logic [CNT_W-1:0]   loads;
    logic signed [31:0] sel, shifted;
    logic [15:0]        sat_val;
    logic               run_exit, load, accept;

    // Source select and scaling act on the live generator inputs of the load cycle.
    always_comb begin
        sel = '0;
        case (cfg_q.mode)
            2'd0:    sel = gauss_in;
            2'd1:    sel = white_in;
            2'd2:    sel = pink_in;
            default: sel = '0;
        endcase
    end

    assign shifted = sel >>> cfg_q.shift;

    always_comb begin
        if (shifted > 32'sd32767)
            sat_val = 16'h7FFF;
        else if (shifted < -32'sd32768)
            sat_val = 16'h8000;
        else
            sat_val = shifted[15:0];
    end

    // stop wins over a same-cycle load; a finite burst closes once all beats are loaded.
    assign run_exit = stop || ((cfg_q.burst != '0) && (loads == cfg_q.burst));
    assign load     = (state == S_RUN) && !run_exit && (!out_valid || out_ready);
    assign accept   = out_valid && out_ready;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_WARM;
            S_WARM: begin
                if (stop)
                    nxt = S_DONE;
                else if (wcnt == WC_W'(1))
                    nxt = S_RUN;
            end
            S_RUN:   if (run_exit) nxt = S_FLUSH;
            S_FLUSH: if (!out_valid || out_ready) nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gen_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            gen_rst <= (nxt == S_IDLE) || (nxt == S_DONE);
            busy    <= (nxt != S_IDLE);
            done    <= (nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= '0;
            wcnt  <= '0;
        end else if (state == S_IDLE && start) begin
            cfg_q <= '{mode: cfg_mode, shift: cfg_shift, burst: cfg_burst};
            wcnt  <= WC_W'(WARMUP_CYC);
        end else if (state == S_WARM) begin
            wcnt  <= wcnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            loads     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) loads <= '0;
                S_RUN: begin
                    if (load) begin
                        out_data  <= $signed(sat_val);
                        out_valid <= 1'b1;
                        loads     <= loads + 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_FLUSH: if (accept) out_valid <= 1'b0;
                S_DONE:  out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // A fresh sample is lost whenever a held beat blocks the load in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            drop_cnt <= '0;
        end else if (state == S_RUN && !load && out_valid && !out_ready) begin
            if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: doc/noise_inject_ctrl.md
# noise_inject_ctrl

Sequencer and stream front-end for the free-running noise generator. It holds the generator in reset while idle, releases it for a warm-up period, then streams a configurable number of scaled, saturated 16-bit noise samples on a valid/ready interface toward the DAC/servo injection path. It also counts samples discarded under backpressure and signals completion.

## Interface
- WARMUP_CYC, 8: cycles after generator reset release before the first sample is taken (covers the generator's pipeline fill).
- CNT_W, 24: width of burst length / beat counters.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  abort a run; sampled in WARMUP and RUN.
- cfg_mode  in  2  source: 0 gaussian, 1 white, 2 pink, 3 zero.
- cfg_shift  in  5  arithmetic right shift applied before saturation.
- cfg_burst  in  CNT_W  beats per run; 0 = continuous until stop.
- gauss_in, white_in, pink_in  in  32 each  signed generator outputs.
- gen_rst  out  1  reset to the generator.
- out_data  out  16  signed sample.
- out_valid  out  1  sample valid.
- out_ready  in  1  consumer accept.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at run end.
- drop_cnt  out  16  samples discarded in the current/last run, saturating.

## Operation
- States: IDLE, WARMUP, RUN, FLUSH, DONE.
- IDLE: gen_rst=1, out_valid=0. On start: latch cfg_mode/cfg_shift/cfg_burst, clear drop_cnt and beat counter, load warm-up counter with WARMUP_CYC, go WARMUP. Config changes outside IDLE have no effect.
- WARMUP: gen_rst=0; decrement counter; at 1 go RUN. stop -> DONE.
- RUN: "load" occurs when (!out_valid || out_ready) and (burst==0 || loads<burst). A load registers sat16(sel >>> shift) into out_data, sets out_valid, and increments loads. Otherwise, if out_valid && !out_ready, that cycle's fresh sample is discarded and drop_cnt increments, saturating at 0xFFFF. If out_ready with no load, out_valid clears.
- RUN exit: when loads==burst (burst!=0) or stop is asserted, perform no further loads and go FLUSH. stop takes priority over a load in the same cycle.
- FLUSH: hold out_data/out_valid until accepted. When !out_valid, or out_valid && out_ready, go DONE. No drop counting.
- DONE: done=1 for one cycle, gen_rst=1, out_valid=0, then IDLE.
- sat16: shifted value > 32767 -> 0x7FFF; < -32768 -> 0x8000; else low 16 bits. Shift is arithmetic (sign-preserving). Mode 3 yields 0.
- start outside IDLE is ignored. start and stop asserted together in IDLE: start is taken; stop is ignored.
- Asynchronous reset at any point: forced to IDLE immediately. The pending sample is lost, no done pulse is issued.

## Timing
- Reset values: gen_rst=1, out_valid=0, out_data=0, busy=0, done=0, drop_cnt=0, state IDLE.
- All outputs are registered.
- start high in cycle 0: WARMUP in cycles 1..WARMUP_CYC with gen_rst=0 and busy=1. RUN begins at cycle WARMUP_CYC+1. The first out_valid=1 appears at cycle WARMUP_CYC+2.
- With out_ready held high, one beat transfers per cycle. Burst N: last beat accepted at cycle WARMUP_CYC+N+1. done pulses 2 cycles after the last accept; gen_rst returns to 1 in the same cycle.
- out_data and out_valid remain stable while out_valid && !out_ready (AXI-stream rule).
- The input sample used by a load is the value present on the input in the load cycle. No additional input registering is done.

## Test plan
- Mode 0, shift 4, burst 4, gauss_in held 0x00012345, ready=1 -> four beats of 0x1234, first valid at cycle 10 (WARMUP_CYC=8), done once, drop_cnt=0.
- Saturation: mode 1, shift 0, white_in=0x7FFFFFFF, then 0x80000000, then 0xFFFFFFF0 -> out_data 0x7FFF, 0x8000, 0xFFF0.
- Backpressure: burst 3, ready low for 5 cycles after the first valid -> out_data stable throughout, drop_cnt=5, exactly 3 beats delivered, done after the third accept.
- Continuous (burst 0), mode 2, stop asserted after 10 accepts with ready low -> FLUSH holds the beat until ready, done follows, and no extra beats occur.
- stop during WARMUP -> no out_valid at all, done one cycle later, gen_rst back to 1. start while busy -> ignored, and latched config is unchanged.
- Async rst asserted mid-RUN with out_valid=1 -> out_valid=0, gen_rst=1, busy=0 immediately, no done. A new start then gives normal run timing.
